// File: rtl/vid_pix_burst_ctrl.sv
// vid_pix_burst_ctrl: FIFO read-side burst sequencer with NAK/timeout rewind-and-replay
module vid_pix_burst_ctrl #(
  parameter int BURST_LEN = 16,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] f_data,
  output logic        f_ena,
  input  logic        f_aempty,
  input  logic        f_empty,
  output logic [4:0]  f_rwd_words,
  output logic        f_rwd_stb,
  output logic [31:0] o_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_first,
  output logic        o_last,
  input  logic        bst_ack,
  input  logic        bst_nak,
  output logic [15:0] stat_retries,
  output logic [15:0] stat_drops,
  output logic        err
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [1:0] {IDLE, BURST, WAIT_STS, REWIND} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [RW-1:0] retry_q;
  logic [15:0] tmr_q;
  logic [15:0] retries_q;
  logic [15:0] drops_q;
  logic        err_q;
  logic        fail;
  assign o_valid      = (state_q == BURST) && !f_empty;
  assign o_data       = f_data;
  assign f_ena        = o_valid && o_ready;
  assign o_first      = o_valid && (cnt_q == 5'd0);
  assign o_last       = o_valid && (cnt_q == 5'(BURST_LEN - 1));
  assign f_rwd_stb    = (state_q == REWIND);
  assign f_rwd_words  = f_rwd_stb ? 5'(BURST_LEN) : 5'd0;
  assign stat_retries = retries_q;
  assign stat_drops   = drops_q;
  assign err          = err_q;
  // tmr_q == 1 is the last wait cycle; NAK beats a simultaneous ACK
  assign fail = bst_nak || (!bst_ack && (tmr_q == 16'd1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      tmr_q     <= '0;
      retries_q <= '0;
      drops_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (enable && !f_aempty) begin
          state_q <= BURST;
          cnt_q   <= '0;
          retry_q <= '0;
        end
        BURST: if (f_ena) begin
          cnt_q <= cnt_q + 5'd1;
          if (o_last) begin
            state_q <= WAIT_STS;
            tmr_q   <= 16'(TIMEOUT);
          end
        end
        WAIT_STS: begin
          tmr_q <= tmr_q - 16'd1;
          if (fail && (retry_q < RW'(MAX_RETRY))) state_q <= REWIND;
          else if (fail) begin
            state_q <= IDLE;
            drops_q <= drops_q + {15'd0, drops_q != 16'hffff};
            err_q   <= 1'b1;
          end else if (bst_ack) state_q <= IDLE;
        end
        REWIND: begin
          state_q   <= BURST;
          cnt_q     <= '0;
          retry_q   <= retry_q + RW'(1);
          retries_q <= retries_q + {15'd0, retries_q != 16'hffff};
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vid_pix_burst_ctrl.sv
// tb_vid_pix_burst_ctrl: directed bench with a FIFO model and a burst-stream reference model
module tb_vid_pix_burst_ctrl;
  localparam int BL = 16;
  localparam int MR = 3;
  localparam int TO = 255;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, o_ready = 1'b1, bst_ack = 1'b0, bst_nak = 1'b0;
  logic [31:0] f_data, o_data;
  logic f_ena, f_aempty, f_empty, f_rwd_stb, o_valid, o_first, o_last, err;
  logic [4:0] f_rwd_words;
  logic [15:0] stat_retries, stat_drops;

  vid_pix_burst_ctrl #(.BURST_LEN(BL), .MAX_RETRY(MR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .f_data(f_data), .f_ena(f_ena),
    .f_aempty(f_aempty), .f_empty(f_empty), .f_rwd_words(f_rwd_words), .f_rwd_stb(f_rwd_stb),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_first(o_first), .o_last(o_last),
    .bst_ack(bst_ack), .bst_nak(bst_nak), .stat_retries(stat_retries), .stat_drops(stat_drops),
    .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO model: word written at index k holds value k
  logic [31:0] mem [0:511];
  int rd = 0, wr = 0, push_target = 0, cyc = 0;
  bit gappy = 0, rnd_ready = 0;
  assign f_data   = mem[rd];
  assign f_empty  = (rd == wr);
  assign f_aempty = (wr - rd) <= 2;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rd <= 0;
      wr <= 0;
    end else begin
      rd <= rd + (f_ena ? 1 : 0) - (f_rwd_stb ? int'(f_rwd_words) : 0);
      if (wr < push_target && (!gappy || $urandom_range(0, 2) != 0)) begin
        mem[wr] <= wr;
        wr <= wr + 1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    o_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference model: phase 0 idle, 1 sending, 2 awaiting status, 3 rewinding
  int ph = 0, idx = 0, att = 0, wc = 0, base = 0, m_ret = 0, m_drop = 0;
  bit m_err = 0, ev;
  int unsigned firsts[$], lasts[$];
  int n_rwd = 0, n_acc = 0, t_last = 0, gap = 0, rwd_w = 0;
  always @(negedge clk) begin
    ev = (ph == 1) && !f_empty;
    chk("o_valid", o_valid, ev);
    chk("f_ena", f_ena, ev && o_ready);
    chk("o_first", o_first, ev && idx == 0);
    chk("o_last", o_last, ev && idx == BL - 1);
    chk("f_rwd_stb", f_rwd_stb, ph == 3);
    chk("f_rwd_words", f_rwd_words, ph == 3 ? BL : 0);
    chk("stat_retries", stat_retries, m_ret);
    chk("stat_drops", stat_drops, m_drop);
    chk("err", err, m_err);
    if (ev) chk("o_data", o_data, base + idx);
    if (f_ena && o_first) firsts.push_back(o_data);
    if (f_ena && o_last) begin lasts.push_back(o_data); t_last = cyc; end
    if (f_ena) n_acc++;
    if (f_rwd_stb) begin n_rwd++; gap = cyc - t_last; rwd_w = f_rwd_words; end
    if (rst) begin
      ph = 0; m_ret = 0; m_drop = 0; m_err = 0; base = 0;
    end else if (ph == 0) begin
      if (enable && !f_aempty) begin ph = 1; idx = 0; att = 0; end
    end else if (ph == 1) begin
      if (ev && o_ready) begin
        if (idx == BL - 1) begin ph = 2; wc = 0; end else idx++;
      end
    end else if (ph == 2) begin
      wc++;
      if (bst_nak || (!bst_ack && wc == TO)) begin
        if (att < MR) ph = 3;
        else begin
          m_drop = m_drop < 65535 ? m_drop + 1 : 65535;
          m_err = 1; base += BL; ph = 0;
        end
      end else if (bst_ack) begin
        ph = 0; base += BL;
      end
    end else begin
      att++; m_ret = m_ret < 65535 ? m_ret + 1 : 65535; ph = 1; idx = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_last();
    bit got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = f_ena && o_last;
    end
    if (!got) chk("wait_last_timeout", 0, 1);
    tick();
  endtask

  // kind: 0 ack, 1 nak, 2 silence, 3 ack+nak together
  task automatic respond(int kind);
    wait_last();
    bst_ack = (kind == 0 || kind == 3);
    bst_nak = (kind == 1 || kind == 3);
    tick();
    bst_ack = 0;
    bst_nak = 0;
  endtask

  task automatic reset_all();
    rst = 1; enable = 0; push_target = 0;
    repeat (3) tick();
    rst = 0;
  endtask

  int f0, r0, a0;
  initial begin
    repeat (3) tick();
    chk("rst_o_valid", o_valid, 0);
    chk("rst_f_ena", f_ena, 0);
    chk("rst_f_rwd_stb", f_rwd_stb, 0);
    chk("rst_f_rwd_words", f_rwd_words, 0);
    chk("rst_err", err, 0);
    chk("rst_stat_retries", stat_retries, 0);
    rst = 0;

    // four clean bursts
    f0 = firsts.size(); r0 = n_rwd;
    push_target = 64; enable = 1;
    repeat (4) respond(0);
    repeat (30) tick();
    chk("t1_bursts", firsts.size() - f0, 4);
    chk("t1_lasts", lasts.size() - f0, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_first_word", firsts[f0 + k], 16 * k);
      chk("t1_last_word", lasts[f0 + k], 16 * k + 15);
    end
    chk("t1_retries", stat_retries, 0);
    chk("t1_rewinds", n_rwd - r0, 0);

    // single NAK then replay
    reset_all();
    f0 = firsts.size(); r0 = n_rwd;
    push_target = 16; enable = 1;
    respond(1);
    respond(0);
    repeat (30) tick();
    chk("t2_rewinds", n_rwd - r0, 1);
    chk("t2_rwd_words", rwd_w, 16);
    chk("t2_retries", stat_retries, 1);
    chk("t2_replay_first", firsts[f0 + 1], 0);

    // NAK every attempt -> drop, then next burst
    reset_all();
    f0 = firsts.size(); r0 = n_rwd;
    push_target = 32; enable = 1;
    repeat (4) respond(1);
    respond(0);
    repeat (30) tick();
    chk("t3_rewinds", n_rwd - r0, 3);
    chk("t3_drops", stat_drops, 1);
    chk("t3_err", err, 1);
    chk("t3_sends", firsts.size() - f0, 5);
    chk("t3_next_first", firsts[f0 + 4], 16);

    // silence -> timeout rewind
    reset_all();
    push_target = 16; enable = 1;
    respond(2);
    respond(0);
    repeat (30) tick();
    chk("t4_timeout_gap", gap, 256);
    chk("t4_retries", stat_retries, 1);

    // random ready, FIFO underruns, ack+nak collision on burst 2
    reset_all();
    a0 = n_acc; gappy = 1; rnd_ready = 1;
    push_target = 64; enable = 1;
    respond(0); respond(0); respond(3); respond(0); respond(0);
    repeat (40) tick();
    gappy = 0; rnd_ready = 0;
    chk("t5_words", n_acc - a0, 80);
    chk("t5_retries", stat_retries, 1);
    chk("t5_final_first", firsts[firsts.size() - 1], 48);

    // reset mid-burst
    reset_all();
    push_target = 32; enable = 1;
    begin
      bit got = 0;
      for (int i = 0; i < 500 && !got; i++) begin
        tick();
        got = o_valid && o_data == 7;
      end
      chk("t6_reach_cnt7", got, 1);
    end
    r0 = n_rwd;
    rst = 1; enable = 0; push_target = 0;
    tick();
    chk("t6_o_valid", o_valid, 0);
    chk("t6_f_ena", f_ena, 0);
    chk("t6_o_first", o_first, 0);
    chk("t6_o_last", o_last, 0);
    chk("t6_f_rwd_stb", f_rwd_stb, 0);
    tick();
    rst = 0;
    repeat (10) tick();
    chk("t6_no_rewind", n_rwd - r0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
